if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the opcode decoder. Holds the PC, issues single-outstanding requests to instruction memory and buffers the returned word.
- Presents the word (and its opcode field) to decode with a valid/ready handshake.
- Applies PC redirects computed from the decoder's 2-bit PC-control encoding: 00 sequential, 01 branch, 10 JAL, 11 JALR.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, word driven on inst when no valid instruction (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
imem_req  output  1  one-cycle request strobe; memory samples imem_addr when high
imem_addr  output  32  fetch address, always equal to pc
imem_rvalid  input  1  response strobe, arrives >=1 cycle after imem_req
imem_rdata  input  32  instruction word, valid with imem_rvalid
inst_valid  output  1  buffered instruction available to decode
inst  output  32  buffered instruction word; NOP_INST when inst_valid=0
inst_pc  output  32  PC of inst
opcode  output  7  inst[6:0], feeds the control decoder
id_ready  input  1  decode accepts inst this cycle
redirect_valid  input  1  PC-control event from execute
pc_ctrl  input  2  00 seq, 01 branch, 10 JAL, 11 JALR
br_taken  input  1  branch condition result, used only when pc_ctrl=01
redirect_base  input  32  PC of the redirecting instruction
imm  input  32  sign-extended immediate
rs1_data  input  32  rs1 value, used for JALR
misalign_err  output  1  one-cycle pulse: redirect target had bit1 set

Behaviour:
- Synchronous active-low reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=IDLE, discard=0.
  - inst_valid=0, inst=NOP_INST, inst_pc=0, misalign_err=0.
  - imem_req=0.
- States:
  - IDLE: one cycle after reset release, go to ISSUE.
  - ISSUE: imem_req = 1 & ~redir, with imem_addr=pc; go to WAIT.
  - WAIT: wait for imem_rvalid.
  - HOLD: instruction buffered, waiting for decode.
- redir = redirect_valid & (pc_ctrl==10 | pc_ctrl==11 | (pc_ctrl==01 & br_taken)).
  - pc_ctrl=00, or 01 with br_taken=0, is a no-event.
- Redirect target (mod 2^32):
  - 01/10: redirect_base+imm.
  - 11: (rs1_data+imm) & ~1.
  - If target[1]=1: misalign_err pulses the next cycle and pc loads {target[31:2],2'b00}.
- Redirect has priority over every sequential action:
  - ISSUE: request suppressed, pc<=target, stay ISSUE.
  - WAIT without rvalid: pc<=target, discard<=1, stay WAIT.
  - WAIT with rvalid in the same cycle: response dropped, pc<=target, go ISSUE.
  - HOLD: buffered instruction dropped (inst_valid=0 next cycle, inst=NOP_INST), pc<=target, go ISSUE.
  - IDLE: pc<=target.
- WAIT on rvalid, no redirect:
  - discard=1: drop the word, clear discard, go ISSUE.
  - Otherwise: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go HOLD.
- HOLD with id_ready=1 and no redirect:
  - inst_valid<=0, inst<=NOP_INST, pc<=pc+4, go ISSUE.
  - pc+4 wraps 0xFFFF_FFFC -> 0.
- HOLD with id_ready=0: inst, inst_pc and inst_valid held stable.
- imem_rvalid outside WAIT is ignored.
- At most one request outstanding.
- Minimum throughput: one instruction per 3 cycles (ISSUE, WAIT with 1-cycle memory, HOLD).
- opcode is combinational from inst[6:0], so it reads 7'b0010011 whenever inst_valid=0.
- Reset mid-operation: all state is discarded. The instruction memory shares rst_n, so no stale response survives reset.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle memory, id_ready=1 -> imem_req pulses at addresses 0x100, 0x104, 0x108. inst_pc matches. opcode=inst[6:0]. inst=0x00000013 between valids.
- id_ready=0 for 5 cycles in HOLD with inst=0x00A00093 -> inst, inst_pc and inst_valid stable. No new imem_req until id_ready=1.
- In HOLD at pc=0x200: redirect with pc_ctrl=10, redirect_base=0x1FC, imm=0x40 -> inst_valid drops, next imem_addr=0x23C.
- In WAIT: JALR with rs1_data=0x1001, imm=0x4 -> target 0x1004. Late response 0xDEADBEEF discarded, never valid. Next fetch at 0x1004.
- Branch, pc_ctrl=01: br_taken=0 -> no effect. br_taken=1 with base+imm=0x302 -> misalign_err pulse, fetch at 0x300.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0. rst_n low during WAIT -> outputs at reset values next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps one request outstanding to
// instruction memory, buffers the returned word and hands it to decode.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [6:0]  opcode,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [1:0]  pc_ctrl,
   input  logic        br_taken,
   input  logic [31:0] redirect_base,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        misalign_q, misalign_d;

   logic        redir;
   logic [31:0] target;
   logic [31:0] redir_pc;

   // Not-taken branches and sequential pc_ctrl are no-events.
   always_comb begin
      redir    = redirect_valid & (pc_ctrl[1] | ((pc_ctrl == 2'b01) & br_taken));
      target   = (pc_ctrl == 2'b11) ? ((rs1_data + imm) & ~32'h1)
                                    : (redirect_base + imm);
      redir_pc = target[1] ? {target[31:2], 2'b00} : target;
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      discard_d    = discard_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      misalign_d   = redir & target[1];
      imem_req     = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = ISSUE;
            if (redir) pc_d = redir_pc;
         end
         ISSUE: begin
            if (redir) begin
               pc_d = redir_pc;
            end else begin
               imem_req = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // A redirect while the request is in flight marks its response stale.
            if (imem_rvalid) begin
               discard_d = 1'b0;
               if (redir) begin
                  pc_d    = redir_pc;
                  state_d = ISSUE;
               end else if (discard_q) begin
                  state_d = ISSUE;
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = HOLD;
               end
            end else if (redir) begin
               pc_d      = redir_pc;
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            if (redir) begin
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               pc_d         = redir_pc;
               state_d      = ISSUE;
            end else if (id_ready) begin
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               pc_d         = pc_q + 32'd4;
               state_d      = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         discard_q    <= 1'b0;
         inst_q       <= NOP_INST;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         discard_q    <= discard_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         misalign_q   <= misalign_d;
      end
   end

   assign imem_addr    = pc_q;
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign inst_valid   = inst_valid_q;
   assign opcode       = inst_q[6:0];
   assign misalign_err = misalign_q;

endmodule
